// File: rtl/cpu24_pkg.sv
// Shared types and constants for the 24-bit CPU control path.
package cpu24_pkg;

    localparam int unsigned OPW    = 4;
    localparam int unsigned ALUOPW = 2;
    localparam int unsigned PERF_W = 24;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5,
        TRAP      = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OPW-1:0] OP_ADDI  = 4'b0001;
    localparam logic [OPW-1:0] OP_LW    = 4'b0010;
    localparam logic [OPW-1:0] OP_SW    = 4'b0011;
    localparam logic [OPW-1:0] OP_BEQ   = 4'b0100;
    localparam logic [OPW-1:0] OP_HALT  = 4'b1111;

    localparam logic [ALUOPW-1:0] ALUOP_ADD  = 2'b00;
    localparam logic [ALUOPW-1:0] ALUOP_SUB  = 2'b01;
    localparam logic [ALUOPW-1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath signal bundle.
// CU_PERF_CNT_EN adds the InstrCount/StallCount performance counters.
interface multicycle_control_unit_if;
    import cpu24_pkg::*;

    logic [OPW-1:0]    opcode;
    logic              MemReady;
    logic              RegDst;
    logic              Branch;
    logic              MemRead;
    logic              MemWrite;
    logic              RegWrite;
    logic              MemToReg;
    logic              ALUSrc;
    logic [ALUOPW-1:0] ALUOp;
    logic              PCWrite;
    logic              IRWrite;
    logic              Halted;
    logic              Illegal;
`ifdef CU_PERF_CNT_EN
    logic [PERF_W-1:0] InstrCount;
    logic [PERF_W-1:0] StallCount;
`endif

    // Control unit side
    modport master (
        input  opcode, MemReady,
        output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
               ALUOp, PCWrite, IRWrite, Halted, Illegal
`ifdef CU_PERF_CNT_EN
        , output InstrCount, StallCount
`endif
    );

    // Datapath side
    modport slave (
        output opcode, MemReady,
        input  RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
               ALUOp, PCWrite, IRWrite, Halted, Illegal
`ifdef CU_PERF_CNT_EN
        , input InstrCount, StallCount
`endif
    );

endinterface

// File: rtl/cu_opclass_decode.sv
// Maps the latched opcode to one-hot instruction class flags.
module cu_opclass_decode
    import cpu24_pkg::*;
(
    input  logic [OPW-1:0] op,
    output logic           is_r,
    output logic           is_addi,
    output logic           is_lw,
    output logic           is_sw,
    output logic           is_beq,
    output logic           is_halt,
    output logic           is_illegal
);

    // Opcode class lookup; anything undefined is illegal
    always_comb begin
        is_r       = 1'b0;
        is_addi    = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_RTYPE: is_r       = 1'b1;
            OP_ADDI:  is_addi    = 1'b1;
            OP_LW:    is_lw      = 1'b1;
            OP_SW:    is_sw      = 1'b1;
            OP_BEQ:   is_beq     = 1'b1;
            OP_HALT:  is_halt    = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer for the 24-bit datapath.
// Optional macro CU_PERF_CNT_EN adds retired-instruction and stall counters.
module multicycle_control_unit
    import cpu24_pkg::*;
(
    input logic                       Clock,
    input logic                       Reset_n,
    multicycle_control_unit_if.master bus
);

    state_t            state_q;
    state_t            state_c;
    logic [OPW-1:0]    op_q;
    logic              is_r, is_addi, is_lw, is_sw, is_beq, is_halt, is_illegal;

    logic              reg_dst_c, branch_c, mem_read_c, mem_write_c, reg_write_c;
    logic              mem_to_reg_c, alu_src_c, pc_write_c, ir_write_c, halted_c, illegal_c;
    logic [ALUOPW-1:0] alu_op_c;

    cu_opclass_decode u_opclass (
        .op         (op_q),
        .is_r       (is_r),
        .is_addi    (is_addi),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= FETCH;
        else          state_q <= state_c;
    end

    // Opcode latch: captured only when leaving FETCH
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)              op_q <= '0;
        else if (state_q == FETCH) op_q <= bus.opcode;
    end

    // Next-state and Moore output decode (MEM exit also looks at MemReady)
    always_comb begin
        state_c      = state_q;
        reg_dst_c    = 1'b0;
        branch_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALUOP_ADD;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        halted_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_c = 1'b1;
                state_c    = DECODE;
            end
            DECODE: begin
                if (is_halt)         state_c = HALTED;
                else if (is_illegal) state_c = TRAP;
                else                 state_c = EXECUTE;
            end
            EXECUTE: begin
                alu_src_c = is_addi | is_lw | is_sw;
                if (is_r)        alu_op_c = ALUOP_FUNC;
                else if (is_beq) alu_op_c = ALUOP_SUB;
                if (is_beq) begin
                    branch_c   = 1'b1;
                    pc_write_c = 1'b1;
                    state_c    = FETCH;
                end else if (is_lw || is_sw) begin
                    state_c = MEM;
                end else begin
                    state_c = WRITEBACK;
                end
            end
            MEM: begin
                alu_src_c   = 1'b1;
                mem_read_c  = is_lw;
                mem_write_c = is_sw;
                if (bus.MemReady) begin
                    if (is_lw) begin
                        state_c = WRITEBACK;
                    end else begin
                        pc_write_c = 1'b1;
                        state_c    = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                reg_dst_c    = is_r;
                alu_src_c    = is_addi;
                mem_to_reg_c = is_lw;
                if (is_r) alu_op_c = ALUOP_FUNC;
                state_c = FETCH;
            end
            HALTED:  halted_c  = 1'b1;
            TRAP:    illegal_c = 1'b1;
            default: state_c   = FETCH;
        endcase
    end

    // Outputs are held low for as long as reset is asserted
    assign bus.RegDst   = Reset_n & reg_dst_c;
    assign bus.Branch   = Reset_n & branch_c;
    assign bus.MemRead  = Reset_n & mem_read_c;
    assign bus.MemWrite = Reset_n & mem_write_c;
    assign bus.RegWrite = Reset_n & reg_write_c;
    assign bus.MemToReg = Reset_n & mem_to_reg_c;
    assign bus.ALUSrc   = Reset_n & alu_src_c;
    assign bus.ALUOp    = {ALUOPW{Reset_n}} & alu_op_c;
    assign bus.PCWrite  = Reset_n & pc_write_c;
    assign bus.IRWrite  = Reset_n & ir_write_c;
    assign bus.Halted   = Reset_n & halted_c;
    assign bus.Illegal  = Reset_n & illegal_c;

`ifdef CU_PERF_CNT_EN
    logic [PERF_W-1:0] instr_cnt_q;
    logic [PERF_W-1:0] stall_cnt_q;

    // Retired-instruction and memory-stall counters, free-running with wrap
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pc_write_c)                         instr_cnt_q <= instr_cnt_q + PERF_W'(1);
            if ((state_q == MEM) && !bus.MemReady)  stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign bus.InstrCount = instr_cnt_q;
    assign bus.StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Build with CU_PERF_CNT_EN defined to also check the performance counters.
module tb_multicycle_control_unit;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b1;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;
`ifdef CU_PERF_CNT_EN
    logic [23:0] exp_instr = '0;
    logic [23:0] exp_stall = '0;
`endif

    // Expected output word: {RegDst,Branch,MemRead,MemWrite,RegWrite,MemToReg,ALUSrc,ALUOp,PCWrite,IRWrite,Halted,Illegal}
    function automatic logic [12:0] ov(input bit rd, input bit br, input bit mr, input bit mw,
                                       input bit rw, input bit m2r, input bit as, input bit [1:0] aop,
                                       input bit pcw, input bit irw, input bit h, input bit il);
        return {rd, br, mr, mw, rw, m2r, as, aop, pcw, irw, h, il};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.RegDst, bus.Branch, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemToReg,
                bus.ALUSrc, bus.ALUOp, bus.PCWrite, bus.IRWrite, bus.Halted, bus.Illegal};
    endfunction

    // Assert reset away from edges, confirm outputs are low, release after a posedge
    task automatic do_reset(input string name);
        Reset_n = 1'b0;
        #1;
        n_vec++;
        if (observed() !== 13'h0) begin
            n_err++;
            $display("FAIL %s async: got %b want %b", name, observed(), 13'h0);
        end
        @(negedge Clock);
        n_vec++;
        if (observed() !== 13'h0) begin
            n_err++;
            $display("FAIL %s held: got %b want %b", name, observed(), 13'h0);
        end
`ifdef CU_PERF_CNT_EN
        exp_instr = '0;
        exp_stall = '0;
        n_vec++;
        if (bus.InstrCount !== 24'h0 || bus.StallCount !== 24'h0) begin
            n_err++;
            $display("FAIL %s counters: got %h/%h want 0/0", name, bus.InstrCount, bus.StallCount);
        end
`endif
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    // Run one instruction from FETCH. Expected per-cycle outputs come from the instruction
    // class: F, D, then class-specific EXECUTE/MEM*/WRITEBACK, or a held HALT/TRAP.
    // max_cyc >= 0 stops after that many cycles, leaving time at the negedge of the last one.
    task automatic run_instr(input logic [3:0] op, input int stalls, input int max_cyc, input string name);
        logic [12:0] exp_q[$];
        bit          mr_q[$];
        bit          memc_q[$];
        bit r, addi, lw, sw, beq, halt, ill;
        logic [12:0] got;
        r    = (op == 4'h0);
        addi = (op == 4'h1);
        lw   = (op == 4'h2);
        sw   = (op == 4'h3);
        beq  = (op == 4'h4);
        halt = (op == 4'hF);
        ill  = !(r | addi | lw | sw | beq | halt);

        exp_q.push_back(ov(0,0,0,0,0,0,0,2'b00,0,1,0,0));
        exp_q.push_back(13'h0);
        if (halt || ill) begin
            repeat (4) exp_q.push_back(ov(0,0,0,0,0,0,0,2'b00,0,0,halt,ill));
        end else begin
            exp_q.push_back(ov(0, beq, 0, 0, 0, 0, addi | lw | sw,
                               r ? 2'b10 : (beq ? 2'b01 : 2'b00), beq, 0, 0, 0));
            if (lw || sw) begin
                for (int k = 0; k <= stalls; k++)
                    exp_q.push_back(ov(0, 0, lw, sw, 0, 0, 1, 2'b00, sw && (k == stalls), 0, 0, 0));
            end
            if (r || addi || lw)
                exp_q.push_back(ov(r, 0, 0, 0, 1, lw, addi, r ? 2'b10 : 2'b00, 1, 0, 0, 0));
        end
        // MemReady: random outside MEM, low for 'stalls' MEM cycles then high
        for (int i = 0; i < exp_q.size(); i++) begin
            bit is_mem;
            is_mem = (lw || sw) && (i >= 3) && (i <= 3 + stalls);
            memc_q.push_back(is_mem);
            if (is_mem) mr_q.push_back(i == 3 + stalls);
            else        mr_q.push_back(1'($urandom));
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            bus.opcode   = (i == 0) ? op : 4'($urandom);
            bus.MemReady = mr_q[i];
            @(negedge Clock);
            got = observed();
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s op=%h cyc%0d: got %b want %b", name, op, i, got, exp_q[i]);
            end
`ifdef CU_PERF_CNT_EN
            n_vec++;
            if (bus.InstrCount !== exp_instr || bus.StallCount !== exp_stall) begin
                n_err++;
                $display("FAIL %s op=%h cyc%0d counters: got %h/%h want %h/%h", name, op, i,
                         bus.InstrCount, bus.StallCount, exp_instr, exp_stall);
            end
            if (exp_q[i][3])              exp_instr = exp_instr + 24'd1;
            if (memc_q[i] && !mr_q[i])    exp_stall = exp_stall + 24'd1;
`endif
            if (max_cyc >= 0 && i == max_cyc - 1) return;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.opcode   = 4'h0;
        bus.MemReady = 1'b0;
        #1;
        do_reset("reset");
    endtask

    task automatic test_reset_mid();
        run_instr(4'h1, 0, 3, "addi_abort");
        do_reset("reset_mid");
        run_instr(4'h1, 0, -1, "addi_after_reset");
    endtask

    task automatic test_rtype();
        run_instr(4'h0, 0, -1, "rtype");
    endtask

    task automatic test_lw_stall();
        run_instr(4'h2, 2, -1, "lw_stall2");
    endtask

    task automatic test_sw();
        run_instr(4'h3, 0, -1, "sw_ready");
    endtask

    task automatic test_beq();
        run_instr(4'h4, 0, -1, "beq");
    endtask

    task automatic test_illegal();
        run_instr(4'h7, 0, -1, "illegal");
        do_reset("reset_after_trap");
    endtask

    task automatic test_halt();
        run_instr(4'h1, 0, -1, "addi_before_halt");
        run_instr(4'hF, 0, -1, "halt");
        do_reset("reset_after_halt");
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 4));
            run_instr(op, int'($urandom_range(0, 3)), -1, "random");
        end
        op = 4'($urandom_range(5, 15));
        run_instr(op, 0, -1, "random_end");
        do_reset("reset_after_random");
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_beq();
        test_illegal();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
